// File: rtl/udp_parser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udp_parser_pkg
//  Description : Shared constants and types for the UDP parser payload path.
//                Holds default beat geometry, the pipeline tag bit layout
//                and the frame-tracking FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package udp_parser_pkg;

    // Default beat geometry for the 40 Gbps datapath
    localparam int LANES_DEF  = 8;
    localparam int LANE_W_DEF = 32;
    localparam int ACC_W_DEF  = 32;

    // Bit positions of the side-band tag carried alongside each beat
    localparam int c_TAG_VALID = 0;
    localparam int c_TAG_SOF   = 1;
    localparam int c_TAG_EOF   = 2;
    localparam int c_TAG_ABORT = 3;
    localparam int c_TAG_W     = 4;

    // Input framing state
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/sum_pipe_tree.sv
`default_nettype none
// ============================================================================
//  Module      : sum_pipe_tree
//  Description : Registered binary adder tree. Sums LANES unsigned words of
//                LANE_W bits in log2(LANES) register stages. Level k is
//                LANE_W+k bits wide so no carry is ever lost. A user tag
//                vector travels alongside with identical latency.
//  Ports       : clk, rst_n        clock / asynchronous active-low reset
//                in_data, in_tag   words (lane i at [i*LANE_W +: LANE_W]), tag
//                out_sum, out_tag  full-precision sum and delayed tag
//  Revision    : 1.0  initial release
// ============================================================================
module sum_pipe_tree #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int TAG_W  = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [LANES*LANE_W-1:0]            in_data,
    input  logic [TAG_W-1:0]                   in_tag,
    output logic [LANE_W+$clog2(LANES)-1:0]    out_sum,
    output logic [TAG_W-1:0]                   out_tag
);

    localparam int c_DEPTH = $clog2(LANES);

    for (genvar k = 1; k <= c_DEPTH; k++) begin : g_level
        localparam int c_NODES = LANES >> k;
        localparam int c_W     = LANE_W + k;

        logic [c_W-1:0]   r_node [c_NODES];
        logic [TAG_W-1:0] r_tag;

        if (k == 1) begin : g_leaf
            // First level pairs up the raw input words
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c_NODES; i++) begin
                        r_node[i] <= '0;
                    end
                    r_tag <= '0;
                end else begin
                    for (int i = 0; i < c_NODES; i++) begin
                        r_node[i] <= {1'b0, in_data[(2*i)*LANE_W +: LANE_W]}
                                   + {1'b0, in_data[(2*i+1)*LANE_W +: LANE_W]};
                    end
                    r_tag <= in_tag;
                end
            end
        end else begin : g_inner
            // Later levels pair up the previous level, widening by one bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c_NODES; i++) begin
                        r_node[i] <= '0;
                    end
                    r_tag <= '0;
                end else begin
                    for (int i = 0; i < c_NODES; i++) begin
                        r_node[i] <= {1'b0, g_level[k-1].r_node[2*i]}
                                   + {1'b0, g_level[k-1].r_node[2*i+1]};
                    end
                    r_tag <= g_level[k-1].r_tag;
                end
            end
        end
    end

    assign out_sum = g_level[c_DEPTH].r_node[0];
    assign out_tag = g_level[c_DEPTH].r_tag;

endmodule
`default_nettype wire

// File: rtl/payload_sum_accum.sv
`default_nettype none
// ============================================================================
//  Module      : payload_sum_accum
//  Description : Pipelined per-frame payload summer. Masks disabled lanes,
//                tracks SOF/EOF framing, reduces each beat through a
//                registered adder tree and accumulates a per-frame sum with
//                sticky overflow and a saturating beat count. One result
//                strobe per completed frame; a pulse on frame abort.
//  Ports       : clk, rst_n                       clock / async active-low reset
//                in_valid, in_sof, in_eof         beat qualifier and framing
//                in_keep, in_data                 lane enables and words
//                out_valid                        one-cycle result strobe
//                out_sum, out_ovf, out_beats      held frame result
//                out_abort                        one-cycle abort pulse
//  Revision    : 1.0  initial release
// ============================================================================
module payload_sum_accum
    import udp_parser_pkg::*;
#(
    parameter int LANES    = LANES_DEF,
    parameter int LANE_W   = LANE_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int SAT_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic                     in_eof,
    input  logic [LANES-1:0]         in_keep,
    input  logic [LANES*LANE_W-1:0]  in_data,
    output logic                     out_valid,
    output logic [ACC_W-1:0]         out_sum,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         out_beats,
    output logic                     out_abort
);

    localparam int c_DEPTH  = $clog2(LANES);
    localparam int c_TREE_W = LANE_W + c_DEPTH;
    // One bit wider than both operands so the carry out of ACC_W is visible
    localparam int c_SUM_W  = ((ACC_W > c_TREE_W) ? ACC_W : c_TREE_W) + 1;

    if ((LANES < 2) || (LANES > 16) || ((LANES & (LANES - 1)) != 0)
            || (ACC_W < LANE_W)) begin : g_param_check
        $error("payload_sum_accum: unsupported LANES/ACC_W combination");
    end

    // ------------------------------------------------------------------
    // Lane masking
    // ------------------------------------------------------------------
    logic [LANES*LANE_W-1:0] w_masked;

    for (genvar i = 0; i < LANES; i++) begin : g_mask
        assign w_masked[i*LANE_W +: LANE_W] = in_keep[i] ? in_data[i*LANE_W +: LANE_W]
                                                         : '0;
    end

    // ------------------------------------------------------------------
    // Input framing FSM and stage 0
    // ------------------------------------------------------------------
    frame_state_t            r_state;
    frame_state_t            w_state_nxt;
    logic                    w_accept;
    logic                    w_abort;
    logic [LANES*LANE_W-1:0] r_s0_data;
    logic [c_TAG_W-1:0]      r_s0_tag;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        if (in_valid) begin
            case (r_state)
                IDLE: begin
                    // Beats outside a frame are dropped unless they open one
                    if (in_sof) begin
                        w_accept    = 1'b1;
                        w_state_nxt = in_eof ? IDLE : IN_FRAME;
                    end
                end
                IN_FRAME: begin
                    // A fresh SOF discards the open frame; the beat itself
                    // becomes the first beat of the new frame
                    w_accept    = 1'b1;
                    w_abort     = in_sof;
                    w_state_nxt = in_eof ? IDLE : IN_FRAME;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_s0_data <= '0;
            r_s0_tag  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_s0_data <= w_masked;
            r_s0_tag  <= {w_abort, in_eof & w_accept, in_sof & w_accept, w_accept};
        end
    end

    // ------------------------------------------------------------------
    // Adder tree
    // ------------------------------------------------------------------
    logic [c_TREE_W-1:0] w_tree_sum;
    logic [c_TAG_W-1:0]  w_tree_tag;

    sum_pipe_tree #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .TAG_W  (c_TAG_W)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (r_s0_data),
        .in_tag  (r_s0_tag),
        .out_sum (w_tree_sum),
        .out_tag (w_tree_tag)
    );

    // ------------------------------------------------------------------
    // Accumulate stage
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_beats;
    logic [c_SUM_W-1:0] w_add;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_ovf_nxt;
    logic [CNT_W-1:0]   w_beats_nxt;

    always_comb begin
        // SOF restarts from zero, so the first beat alone can overflow
        if (w_tree_tag[c_TAG_SOF]) begin
            w_add = c_SUM_W'(w_tree_sum);
        end else begin
            w_add = c_SUM_W'(r_acc) + c_SUM_W'(w_tree_sum);
        end

        w_carry = |w_add[c_SUM_W-1:ACC_W];

        // Once clamped, any further non-zero beat overflows again, so the
        // accumulator stays pinned at all-ones without extra state
        if ((SAT_MODE != 0) && w_carry) begin
            w_acc_nxt = '1;
        end else begin
            w_acc_nxt = w_add[ACC_W-1:0];
        end

        w_ovf_nxt = w_tree_tag[c_TAG_SOF] ? w_carry : (r_ovf | w_carry);

        if (w_tree_tag[c_TAG_SOF]) begin
            w_beats_nxt = CNT_W'(1);
        end else if (&r_beats) begin
            w_beats_nxt = r_beats;
        end else begin
            w_beats_nxt = r_beats + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_beats   <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_beats <= '0;
            out_abort <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_abort <= 1'b0;
            if (w_tree_tag[c_TAG_VALID]) begin
                r_acc     <= w_acc_nxt;
                r_ovf     <= w_ovf_nxt;
                r_beats   <= w_beats_nxt;
                out_abort <= w_tree_tag[c_TAG_ABORT];
                if (w_tree_tag[c_TAG_EOF]) begin
                    out_valid <= 1'b1;
                    out_sum   <= w_acc_nxt;
                    out_ovf   <= w_ovf_nxt;
                    out_beats <= w_beats_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_payload_sum_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_payload_sum_accum
//  Description : Directed self-checking bench for payload_sum_accum. Two
//                instances share one stimulus stream: a wrapping one with a
//                16-bit beat counter and a saturating one with a 2-bit beat
//                counter. Strobes and abort pulses are logged with the cycle
//                they appear in and compared against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_payload_sum_accum;

    localparam int LANES  = 8;
    localparam int LANE_W = 32;
    localparam int DW     = LANES * LANE_W;
    localparam int LAT    = 5;   // beat presented in cycle c -> strobe in cycle c+5

    typedef struct {
        int          cyc;
        logic [31:0] sum;
        logic        ovf;
        logic [15:0] beats;
    } strobe_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic             in_eof = 1'b0;
    logic [LANES-1:0] in_keep = '0;
    logic [DW-1:0]    in_data = '0;

    logic        out_valid, out_ovf, out_abort;
    logic [31:0] out_sum;
    logic [15:0] out_beats;
    logic        sat_out_valid, sat_out_ovf, sat_out_abort;
    logic [31:0] sat_out_sum;
    logic [1:0]  sat_out_beats;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    strobe_t q_main[$];
    strobe_t q_sat[$];
    int      q_abort[$];
    int      q_sat_abort[$];

    payload_sum_accum #(.LANES(8), .LANE_W(32), .ACC_W(32), .SAT_MODE(0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .in_keep(in_keep), .in_data(in_data), .out_valid(out_valid), .out_sum(out_sum),
        .out_ovf(out_ovf), .out_beats(out_beats), .out_abort(out_abort));

    payload_sum_accum #(.LANES(8), .LANE_W(32), .ACC_W(32), .SAT_MODE(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .in_keep(in_keep), .in_data(in_data), .out_valid(sat_out_valid), .out_sum(sat_out_sum),
        .out_ovf(sat_out_ovf), .out_beats(sat_out_beats), .out_abort(sat_out_abort));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe / abort on the falling edge, tagged with its cycle
    always @(negedge clk) begin
        if (out_valid)     q_main.push_back('{cyc, out_sum, out_ovf, out_beats});
        if (sat_out_valid) q_sat.push_back('{cyc, sat_out_sum, sat_out_ovf, {14'd0, sat_out_beats}});
        if (out_abort)     q_abort.push_back(cyc);
        if (sat_out_abort) q_sat_abort.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        q_main.delete(); q_sat.delete(); q_abort.delete(); q_sat_abort.delete();
    endtask

    task automatic beat(input logic sof, input logic eof, input logic [LANES-1:0] keep,
                        input logic [DW-1:0] data);
        in_valid = 1'b1; in_sof = sof; in_eof = eof; in_keep = keep; in_data = data;
        tick();
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_keep = '0; in_data = '0;
    endtask

    function automatic logic [DW-1:0] fill(input logic [31:0] w);
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*LANE_W +: LANE_W] = w;
        return d;
    endfunction

    function automatic logic [DW-1:0] ramp();
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*LANE_W +: LANE_W] = 32'(i + 1);
        return d;
    endfunction

    function automatic logic [DW-1:0] words2(input logic [31:0] w0, input logic [31:0] w1);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]  = w0;
        d[63:32] = w1;
        return d;
    endfunction

    function automatic strobe_t pick(input strobe_t q[$], input int idx);
        strobe_t s;
        s = '{-1, 32'hDEAD_BEEF, 1'b1, 16'hDEAD};
        if (idx < q.size()) s = q[idx];
        return s;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        n_vec++; if (out_valid !== 1'b0)     begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_vec++; if (out_sum !== 32'd0)      begin n_err++; $display("FAIL rst_sum: got %h want 0", out_sum); end
        n_vec++; if (out_ovf !== 1'b0)       begin n_err++; $display("FAIL rst_ovf: got %b want 0", out_ovf); end
        n_vec++; if (out_beats !== 16'd0)    begin n_err++; $display("FAIL rst_beats: got %0d want 0", out_beats); end
        n_vec++; if (out_abort !== 1'b0)     begin n_err++; $display("FAIL rst_abort: got %b want 0", out_abort); end
        n_vec++; if (sat_out_sum !== 32'd0)  begin n_err++; $display("FAIL rst_sat_sum: got %h want 0", sat_out_sum); end
        n_vec++; if (sat_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_sat_valid: got %b want 0", sat_out_valid); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single_beat();
        int e; strobe_t s;
        clear_logs();
        e = cyc; beat(1'b1, 1'b1, 8'hFF, ramp());
        idle(LAT - 2);
        // one cycle before the strobe is due nothing may have appeared yet
        n_vec++; if (q_main.size() != 0) begin n_err++; $display("FAIL single_early: got %0d strobes want 0", q_main.size()); end
        idle(5);
        s = pick(q_main, 0);
        n_vec++; if (q_main.size() != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", q_main.size()); end
        n_vec++; if (s.cyc != e + LAT)   begin n_err++; $display("FAIL single_latency: got cycle %0d want %0d", s.cyc, e + LAT); end
        n_vec++; if (s.sum !== 32'd36)   begin n_err++; $display("FAIL single_sum: got %0d want 36", s.sum); end
        n_vec++; if (s.beats !== 16'd1)  begin n_err++; $display("FAIL single_beats: got %0d want 1", s.beats); end
        n_vec++; if (s.ovf !== 1'b0)     begin n_err++; $display("FAIL single_ovf: got %b want 0", s.ovf); end
        s = pick(q_sat, 0);
        n_vec++; if (s.sum !== 32'd36)   begin n_err++; $display("FAIL single_sat_sum: got %0d want 36", s.sum); end
    endtask

    task automatic test_back_to_back();
        int e1, e2; strobe_t s;
        clear_logs();
        beat(1'b1, 1'b0, 8'hFF, fill(32'h10));
        beat(1'b0, 1'b0, 8'h0F, fill(32'h10));
        e1 = cyc; beat(1'b0, 1'b1, 8'hFF, fill(32'h10));
        e2 = cyc; beat(1'b1, 1'b1, 8'hFF, fill(32'h1));
        idle(8);
        n_vec++; if (q_main.size() != 2)  begin n_err++; $display("FAIL b2b_count: got %0d want 2", q_main.size()); end
        s = pick(q_main, 0);
        n_vec++; if (s.cyc != e1 + LAT)   begin n_err++; $display("FAIL b2b_lat1: got cycle %0d want %0d", s.cyc, e1 + LAT); end
        n_vec++; if (s.sum !== 32'h140)   begin n_err++; $display("FAIL b2b_sum1: got %h want 140", s.sum); end
        n_vec++; if (s.beats !== 16'd3)   begin n_err++; $display("FAIL b2b_beats1: got %0d want 3", s.beats); end
        s = pick(q_main, 1);
        n_vec++; if (s.cyc != e2 + LAT)   begin n_err++; $display("FAIL b2b_lat2: got cycle %0d want %0d", s.cyc, e2 + LAT); end
        n_vec++; if (s.sum !== 32'd8)     begin n_err++; $display("FAIL b2b_sum2: got %0d want 8", s.sum); end
        n_vec++; if (s.beats !== 16'd1)   begin n_err++; $display("FAIL b2b_beats2: got %0d want 1", s.beats); end
        s = pick(q_sat, 0);
        n_vec++; if (s.beats !== 16'd3)   begin n_err++; $display("FAIL b2b_sat_beats1: got %0d want 3", s.beats); end
        n_vec++; if (q_abort.size() != 0) begin n_err++; $display("FAIL b2b_abort: got %0d pulses want 0", q_abort.size()); end
        n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL b2b_hold_valid: got %b want 0", out_valid); end
        n_vec++; if (out_sum !== 32'd8)   begin n_err++; $display("FAIL b2b_hold_sum: got %0d want 8", out_sum); end
    endtask

    task automatic test_overflow();
        strobe_t s;
        clear_logs();
        beat(1'b1, 1'b0, 8'hFF, fill(32'hFFFF_FFFF));
        beat(1'b0, 1'b1, 8'hFF, fill(32'hFFFF_FFFF));
        // exactly 2^32 in one beat, then exactly 2^32-1
        beat(1'b1, 1'b1, 8'hFF, words2(32'hFFFF_FFFF, 32'h1));
        beat(1'b1, 1'b1, 8'hFF, words2(32'hFFFF_FFFE, 32'h1));
        idle(8);
        n_vec++; if (q_main.size() != 3)       begin n_err++; $display("FAIL ovf_count: got %0d want 3", q_main.size()); end
        s = pick(q_main, 0);
        n_vec++; if (s.sum !== 32'hFFFF_FFF0)  begin n_err++; $display("FAIL ovf_wrap_sum: got %h want fffffff0", s.sum); end
        n_vec++; if (s.ovf !== 1'b1)           begin n_err++; $display("FAIL ovf_wrap_flag: got %b want 1", s.ovf); end
        n_vec++; if (s.beats !== 16'd2)        begin n_err++; $display("FAIL ovf_wrap_beats: got %0d want 2", s.beats); end
        s = pick(q_sat, 0);
        n_vec++; if (s.sum !== 32'hFFFF_FFFF)  begin n_err++; $display("FAIL ovf_sat_sum: got %h want ffffffff", s.sum); end
        n_vec++; if (s.ovf !== 1'b1)           begin n_err++; $display("FAIL ovf_sat_flag: got %b want 1", s.ovf); end
        s = pick(q_main, 1);
        n_vec++; if (s.sum !== 32'h0)          begin n_err++; $display("FAIL ovf_edge_wrap_sum: got %h want 0", s.sum); end
        n_vec++; if (s.ovf !== 1'b1)           begin n_err++; $display("FAIL ovf_edge_wrap_flag: got %b want 1", s.ovf); end
        s = pick(q_sat, 1);
        n_vec++; if (s.sum !== 32'hFFFF_FFFF)  begin n_err++; $display("FAIL ovf_edge_sat_sum: got %h want ffffffff", s.sum); end
        s = pick(q_main, 2);
        n_vec++; if (s.sum !== 32'hFFFF_FFFF)  begin n_err++; $display("FAIL ovf_below_sum: got %h want ffffffff", s.sum); end
        n_vec++; if (s.ovf !== 1'b0)           begin n_err++; $display("FAIL ovf_below_flag: got %b want 0", s.ovf); end
        s = pick(q_sat, 2);
        n_vec++; if (s.ovf !== 1'b0)           begin n_err++; $display("FAIL ovf_below_sat_flag: got %b want 0", s.ovf); end
    endtask

    task automatic test_abort();
        int ea, e, eb; strobe_t s;
        clear_logs();
        beat(1'b1, 1'b0, 8'hFF, fill(32'd2));
        ea = cyc; beat(1'b1, 1'b0, 8'hFF, fill(32'd3));
        e = cyc;  beat(1'b0, 1'b1, 8'hFF, fill(32'd5));
        idle(8);
        n_vec++; if (q_abort.size() != 1)     begin n_err++; $display("FAIL abort_count: got %0d want 1", q_abort.size()); end
        n_vec++; if ((q_abort.size() > 0 ? q_abort[0] : -1) != ea + LAT)
                                              begin n_err++; $display("FAIL abort_cycle: got %0d want %0d", (q_abort.size() > 0 ? q_abort[0] : -1), ea + LAT); end
        n_vec++; if (q_sat_abort.size() != 1) begin n_err++; $display("FAIL abort_sat_count: got %0d want 1", q_sat_abort.size()); end
        n_vec++; if (q_main.size() != 1)      begin n_err++; $display("FAIL abort_strobes: got %0d want 1", q_main.size()); end
        s = pick(q_main, 0);
        n_vec++; if (s.cyc != e + LAT)        begin n_err++; $display("FAIL abort_latency: got cycle %0d want %0d", s.cyc, e + LAT); end
        n_vec++; if (s.sum !== 32'd64)        begin n_err++; $display("FAIL abort_sum: got %0d want 64", s.sum); end
        n_vec++; if (s.beats !== 16'd2)       begin n_err++; $display("FAIL abort_beats: got %0d want 2", s.beats); end
        // SOF+EOF inside an open frame: abort and single-beat result together
        clear_logs();
        beat(1'b1, 1'b0, 8'hFF, fill(32'd4));
        eb = cyc; beat(1'b1, 1'b1, 8'hFF, fill(32'd6));
        idle(8);
        s = pick(q_main, 0);
        n_vec++; if ((q_abort.size() > 0 ? q_abort[0] : -1) != eb + LAT)
                                              begin n_err++; $display("FAIL abort_se_cycle: got %0d want %0d", (q_abort.size() > 0 ? q_abort[0] : -1), eb + LAT); end
        n_vec++; if (s.cyc != eb + LAT)       begin n_err++; $display("FAIL abort_se_latency: got cycle %0d want %0d", s.cyc, eb + LAT); end
        n_vec++; if (s.sum !== 32'd48)        begin n_err++; $display("FAIL abort_se_sum: got %0d want 48", s.sum); end
        n_vec++; if (s.beats !== 16'd1)       begin n_err++; $display("FAIL abort_se_beats: got %0d want 1", s.beats); end
    endtask

    task automatic test_orphan();
        strobe_t s;
        clear_logs();
        beat(1'b0, 1'b0, 8'hFF, fill(32'd7));
        beat(1'b0, 1'b1, 8'hFF, fill(32'd7));
        // framing flags without in_valid must be ignored
        in_sof = 1'b1; in_eof = 1'b1; in_keep = 8'hFF; in_data = fill(32'd9);
        tick();
        in_sof = 1'b0; in_eof = 1'b0; in_keep = '0; in_data = '0;
        idle(8);
        n_vec++; if (q_main.size() != 0)  begin n_err++; $display("FAIL orphan_strobes: got %0d want 0", q_main.size()); end
        n_vec++; if (q_abort.size() != 0) begin n_err++; $display("FAIL orphan_abort: got %0d want 0", q_abort.size()); end
        n_vec++; if (out_sum !== 32'd48)  begin n_err++; $display("FAIL orphan_hold_sum: got %0d want 48", out_sum); end
        beat(1'b1, 1'b0, 8'hFF, fill(32'd1));
        beat(1'b0, 1'b1, 8'h01, fill(32'd1));
        idle(8);
        s = pick(q_main, 0);
        n_vec++; if (q_main.size() != 1)  begin n_err++; $display("FAIL orphan_next_count: got %0d want 1", q_main.size()); end
        n_vec++; if (s.sum !== 32'd9)     begin n_err++; $display("FAIL orphan_next_sum: got %0d want 9", s.sum); end
        n_vec++; if (s.beats !== 16'd2)   begin n_err++; $display("FAIL orphan_next_beats: got %0d want 2", s.beats); end
    endtask

    task automatic test_beat_saturate();
        strobe_t s;
        clear_logs();
        beat(1'b1, 1'b0, 8'hFF, fill(32'd1));
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 8'hFF, fill(32'd1));
        beat(1'b0, 1'b1, 8'hFF, fill(32'd1));
        idle(8);
        s = pick(q_main, 0);
        n_vec++; if (s.sum !== 32'd40)  begin n_err++; $display("FAIL sat_cnt_sum: got %0d want 40", s.sum); end
        n_vec++; if (s.beats !== 16'd5) begin n_err++; $display("FAIL sat_cnt_wide: got %0d want 5", s.beats); end
        s = pick(q_sat, 0);
        n_vec++; if (s.beats !== 16'd3) begin n_err++; $display("FAIL sat_cnt_narrow: got %0d want 3", s.beats); end
    endtask

    task automatic test_reset_mid_frame();
        int e; strobe_t s;
        clear_logs();
        beat(1'b1, 1'b0, 8'hFF, fill(32'd9));
        beat(1'b0, 1'b0, 8'hFF, fill(32'd9));
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_sum !== 32'd0)     begin n_err++; $display("FAIL midrst_sum: got %0d want 0", out_sum); end
        n_vec++; if (out_beats !== 16'd0)   begin n_err++; $display("FAIL midrst_beats: got %0d want 0", out_beats); end
        n_vec++; if (sat_out_beats !== 2'd0) begin n_err++; $display("FAIL midrst_sat_beats: got %0d want 0", sat_out_beats); end
        tick();
        rst_n = 1'b1;
        beat(1'b0, 1'b1, 8'hFF, fill(32'd9));
        idle(8);
        n_vec++; if (q_main.size() != 0)    begin n_err++; $display("FAIL midrst_strobes: got %0d want 0", q_main.size()); end
        n_vec++; if (q_abort.size() != 0)   begin n_err++; $display("FAIL midrst_abort: got %0d want 0", q_abort.size()); end
        beat(1'b1, 1'b0, 8'h00, fill(32'd5));
        e = cyc; beat(1'b0, 1'b1, 8'hFF, ramp());
        idle(8);
        s = pick(q_main, 0);
        n_vec++; if (s.cyc != e + LAT)      begin n_err++; $display("FAIL midrst_clean_latency: got cycle %0d want %0d", s.cyc, e + LAT); end
        n_vec++; if (s.sum !== 32'd36)      begin n_err++; $display("FAIL midrst_clean_sum: got %0d want 36", s.sum); end
        n_vec++; if (s.beats !== 16'd2)     begin n_err++; $display("FAIL midrst_clean_beats: got %0d want 2", s.beats); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_orphan();
        test_beat_saturate();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/payload_sum_accum.md
Name: payload_sum_accum

Overview:
- Parametrised, pipelined payload summer for the 40 Gbps UDP parser.
- Each accepted beat carries LANES unsigned words; lanes not flagged in in_keep are masked to zero.
- Per-frame running sum is framed by SOF/EOF. One result (sum, overflow flag, beat count) is reported per frame.
- Sits after payload extraction; feeds the checksum/statistics stage. Streaming only, no backpressure.

Parameters:
- LANES, 8, words per beat; power of two, range 2..16.
- LANE_W, 32, bits per word.
- ACC_W, 32, accumulator/result width; must be >= LANE_W.
- SAT_MODE, 0, 0 = accumulator wraps modulo 2^ACC_W; 1 = accumulator saturates at 2^ACC_W-1.
- CNT_W, 16, beat-counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat qualifier.
- in_sof  in  1  first beat of frame; qualified by in_valid.
- in_eof  in  1  last beat of frame; qualified by in_valid.
- in_keep  in  LANES  lane enable; bit i enables word i.
- in_data  in  LANES*LANE_W  word i = in_data[i*LANE_W +: LANE_W].
- out_valid  out  1  one-cycle result strobe.
- out_sum  out  ACC_W  frame sum.
- out_ovf  out  1  any overflow of ACC_W occurred during the frame.
- out_beats  out  CNT_W  beats in the frame; saturates at all-ones.
- out_abort  out  1  one-cycle pulse when an open frame is discarded.

Behaviour:
- Reset: all outputs, pipeline valid/tag bits, accumulator, counter and FSM go to 0/IDLE immediately. Any frame in flight is lost and produces no out_valid and no out_abort.
- Input FSM is evaluated only on in_valid=1.
  - IDLE: a beat with sof moves to IN_FRAME, or stays IDLE if eof is also set (single-beat frame). A beat without sof is dropped (not summed).
  - IN_FRAME: eof returns to IDLE. A beat with sof and no eof aborts the open frame and starts a new one in IN_FRAME. A beat with sof and eof aborts the open frame and is itself a complete single-beat frame; FSM returns to IDLE.
- Pipeline:
  - Stage 0 registers masked lanes plus tags {sof, eof, abort}.
  - D = log2(LANES) adder-tree stages follow. Level k is LANE_W+k bits wide, so the tree is lossless.
  - One accumulate stage completes the pipeline.
  - All stages advance every cycle. Bubbles carry valid=0 and do not alter the accumulator.
- Accumulate stage:
  - sof beat: acc = tree_sum; ovf = (tree_sum >= 2^ACC_W); beats = 1.
  - Other beats: acc = acc + tree_sum; ovf |= carry beyond ACC_W.
  - SAT_MODE=1: on overflow, acc is clamped to all-ones and stays there.
  - SAT_MODE=0: acc keeps the low ACC_W bits.
- Latency: out_valid rises exactly D+2 cycles after the eof beat is sampled (5 cycles for LANES=8). out_sum includes the eof beat.
- out_sum, out_ovf and out_beats are held between strobes.
- out_abort is asserted in the accumulate-stage cycle of the aborting sof beat. out_valid is not asserted for the aborted frame.
- Back-to-back frames (eof then sof on consecutive cycles) are supported with zero dead cycles.
- in_keep=0 beats count in out_beats and add 0.

Decomposition:
- Package udp_parser_pkg holds default constants (LANES_DEF, LANE_W_DEF, ACC_W_DEF) and the typedef for the FSM state enum {IDLE, IN_FRAME}.
- One sub-module, sum_pipe_tree: parameters LANES and LANE_W; a registered binary adder tree with latency D that passes through a user tag vector.
- Top level contains the masking stage, FSM, accumulator, counter and output registers.

Test Plan:
- Single-beat frame, LANES=8: words 1..8, keep=8'hFF, sof=eof=1. Expect out_valid 5 cycles later, out_sum=36, out_beats=1, out_ovf=0.
- Three-beat frame: words all 32'h10, beat 2 with keep=8'h0F. Expect out_sum=32'h140, out_beats=3; then an immediate back-to-back frame of all 1s gives a second strobe one cycle after the first with out_sum=8.
- Overflow: two beats, each word 32'hFFFF_FFFF. SAT_MODE=0 gives out_sum=32'hFFFF_FFF0, out_ovf=1. SAT_MODE=1 gives out_sum=32'hFFFF_FFFF, out_ovf=1.
- Abort: sof beat, then a sof-only beat, then an eof beat. Expect one out_abort pulse, and a single out_valid whose sum covers only the last two beats.
- Orphan beats: in_valid beats without sof while IDLE. Expect no out_valid, no out_abort, and the accumulator unchanged for the next frame.
- Reset mid-frame: drop rst_n two cycles after sof. Expect outputs 0 immediately, no strobe afterwards, and a following clean frame summing correctly.
